// File: rtl/multicycle_controller.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer with req/ack memory handshakes and a sticky timeout fault.
// Optional perf counters (cycle_count, instret_count) are built when MULTICYCLE_PERF_CNT_EN is defined.
module multicycle_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    input  logic       dec_reg_write,
    input  logic       dec_mem_read,
    input  logic       dec_mem_write,
    input  logic       dec_branch,
    input  logic       dec_jump,
    input  logic       branch_taken,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_we,
    output logic       mdr_we,
    output logic       rf_we,
    output logic       pc_we,
    output logic       pc_sel,
    output logic [2:0] state,
    output logic       fault
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
`endif
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_FAULT   = 3'd7
    } state_e;

    // Timeout fires on the last allowed waiting cycle, so an ack in that cycle still wins.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic             pc_sel_q, pc_sel_d;
    logic             ireq_hold_q, ireq_hold_d;

    logic             req_c;
    logic             ack_c;
    logic             timeout_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            cnt_q       <= '0;
            fault_q     <= 1'b0;
            pc_sel_q    <= 1'b0;
            ireq_hold_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fault_q     <= fault_d;
            pc_sel_q    <= pc_sel_d;
            ireq_hold_q <= ireq_hold_d;
        end
    end

    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        mdr_we    = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        state_d   = state_q;
        pc_sel_d  = pc_sel_q;

        req_c     = 1'b0;
        ack_c     = 1'b0;
        timeout_c = 1'b0;

        // Request/ack decode first so the timeout check sees this cycle's handshake.
        if (state_q == S_FETCH) begin
            imem_req = run | ireq_hold_q;
        end
        if (state_q == S_MEM) begin
            dmem_req = 1'b1;
            dmem_we  = dec_mem_write;
        end
        req_c     = imem_req | dmem_req;
        ack_c     = (imem_req & imem_ack) | (dmem_req & dmem_ack);
        timeout_c = req_c & ~ack_c & (cnt_q == CNT_LAST);

        unique case (state_q)
            S_FETCH: begin
                if (imem_req && imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_c) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                pc_sel_d = dec_jump | (dec_branch & branch_taken);
                state_d  = (dec_mem_read | dec_mem_write) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    mdr_we  = ~dmem_we;
                    state_d = S_WB;
                end else if (timeout_c) begin
                    state_d = S_FAULT;
                end
            end
            S_WB: begin
                rf_we   = dec_reg_write;
                pc_we   = 1'b1;
                pc_sel  = pc_sel_q;
                state_d = S_FETCH;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q + CNT_W'(1);
        ireq_hold_d = imem_req & ~imem_ack & (state_d == S_FETCH);
        fault_d     = fault_q | (state_d == S_FAULT);
        if (!req_c || ack_c || (state_d != state_q)) begin
            cnt_d = '0;
        end
    end

    assign state = state_q;
    assign fault = fault_q;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, instret_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else if (state_q != S_FAULT) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (state_q == S_WB) begin
                instret_cnt_q <= instret_cnt_q + 32'd1;
            end
        end
    end

    assign cycle_count   = cycle_cnt_q;
    assign instret_count = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller (TIMEOUT_CYCLES = 4).
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst, run, imem_ack, dmem_ack;
    logic       dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump, branch_taken;
    logic       imem_req, dmem_req, dmem_we, ir_we, mdr_we, rf_we, pc_we, pc_sel, fault;
    logic [2:0] state;
`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_count, instret_count;
`endif

    always #5 clk = ~clk;

    multicycle_controller #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
        .dec_mem_write(dec_mem_write), .dec_branch(dec_branch), .dec_jump(dec_jump),
        .branch_taken(branch_taken), .imem_req(imem_req), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .ir_we(ir_we), .mdr_we(mdr_we), .rf_we(rf_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .state(state), .fault(fault)
`ifdef MULTICYCLE_PERF_CNT_EN
        , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
    );

    // in  = {rst, run, imem_ack, dmem_ack, reg_write, mem_read, mem_write, branch, jump, taken}
    // out = {imem_req, dmem_req, dmem_we, ir_we, mdr_we, rf_we, pc_we, pc_sel, fault}
    typedef struct packed {
        logic [9:0] in;
        logic [2:0] st;
        logic [8:0] out;
    } vec_t;

    vec_t tv[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc_m  = 0;
    int   ret_m  = 0;

    task automatic add(input logic [9:0] in, input logic [2:0] st, input logic [8:0] out);
        vec_t v;
        v.in = in; v.st = st; v.out = out;
        tv.push_back(v);
    endtask

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s #%0d: got %0h expected %0h", nm, idx, act, exp);
    endtask

    // One cycle: drive inputs, compare state/outputs mid-cycle, advance past the edge.
    task automatic step(input int idx, input logic [9:0] in, input logic [2:0] st, input logic [8:0] out);
        {rst, run, imem_ack, dmem_ack, dec_reg_write, dec_mem_read,
         dec_mem_write, dec_branch, dec_jump, branch_taken} = in;
        @(negedge clk);
        check("state", idx, {29'd0, state}, {29'd0, st});
        check("outputs", idx,
              {23'd0, imem_req, dmem_req, dmem_we, ir_we, mdr_we, rf_we, pc_we, pc_sel, fault},
              {23'd0, out});
        if (in[9]) begin
            cyc_m = 0; ret_m = 0;
        end else if (st != 3'd7) begin
            cyc_m++;
            if (st == 3'd4) ret_m++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset and idle
        add(10'b1000_000000, 3'd0, 9'b000_0000_00);
        // ALU
        add(10'b0110_100000, 3'd0, 9'b100_1000_00);
        add(10'b0110_100000, 3'd1, 9'b000_0000_00);
        add(10'b0110_100000, 3'd2, 9'b000_0000_00);
        add(10'b0000_100000, 3'd4, 9'b000_0011_00);
        // run gating and spurious ack
        add(10'b0000_000000, 3'd0, 9'b000_0000_00);
        add(10'b0010_000000, 3'd0, 9'b000_0000_00);
        // branch taken
        add(10'b0110_000101, 3'd0, 9'b100_1000_00);
        add(10'b0110_000101, 3'd1, 9'b000_0000_00);
        add(10'b0110_000101, 3'd2, 9'b000_0000_00);
        add(10'b0000_000101, 3'd4, 9'b000_0001_10);
        // branch not taken
        add(10'b0110_000100, 3'd0, 9'b100_1000_00);
        add(10'b0110_000100, 3'd1, 9'b000_0000_00);
        add(10'b0110_000100, 3'd2, 9'b000_0000_00);
        add(10'b0000_000100, 3'd4, 9'b000_0001_00);
        // jump with link
        add(10'b0110_100010, 3'd0, 9'b100_1000_00);
        add(10'b0110_100010, 3'd1, 9'b000_0000_00);
        add(10'b0110_100010, 3'd2, 9'b000_0000_00);
        add(10'b0000_100010, 3'd4, 9'b000_0011_10);
        // store, immediate ack
        add(10'b0110_001000, 3'd0, 9'b100_1000_00);
        add(10'b0110_001000, 3'd1, 9'b000_0000_00);
        add(10'b0110_001000, 3'd2, 9'b000_0000_00);
        add(10'b0001_001000, 3'd3, 9'b011_0000_00);
        add(10'b0000_001000, 3'd4, 9'b000_0001_00);
        // read and write both set: treated as store
        add(10'b0110_011000, 3'd0, 9'b100_1000_00);
        add(10'b0110_011000, 3'd1, 9'b000_0000_00);
        add(10'b0110_011000, 3'd2, 9'b000_0000_00);
        add(10'b0001_011000, 3'd3, 9'b011_0000_00);
        add(10'b0000_011000, 3'd4, 9'b000_0001_00);
        // load, dmem_ack three cycles after MEM entry: 8 cycles total
        add(10'b0110_110000, 3'd0, 9'b100_1000_00);
        add(10'b0110_110000, 3'd1, 9'b000_0000_00);
        add(10'b0110_110000, 3'd2, 9'b000_0000_00);
        add(10'b0000_110000, 3'd3, 9'b010_0000_00);
        add(10'b0000_110000, 3'd3, 9'b010_0000_00);
        add(10'b0000_110000, 3'd3, 9'b010_0000_00);
        add(10'b0001_110000, 3'd3, 9'b010_0100_00);
        add(10'b0000_110000, 3'd4, 9'b000_0011_00);
        // run drops after imem_req rises: request holds until ack
        add(10'b0100_000000, 3'd0, 9'b100_0000_00);
        add(10'b0000_000000, 3'd0, 9'b100_0000_00);
        add(10'b0010_000000, 3'd0, 9'b100_1000_00);
        add(10'b0000_000000, 3'd1, 9'b000_0000_00);
        add(10'b0000_000000, 3'd2, 9'b000_0000_00);
        add(10'b0000_000000, 3'd4, 9'b000_0001_00);

        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        dec_reg_write = 1'b0; dec_mem_read = 1'b0; dec_mem_write = 1'b0;
        dec_branch = 1'b0; dec_jump = 1'b0; branch_taken = 1'b0;
        @(posedge clk);
        #1;

        foreach (tv[i]) step(i, tv[i].in, tv[i].st, tv[i].out);

`ifdef MULTICYCLE_PERF_CNT_EN
        @(negedge clk);
        check("cycle_count", 0, cycle_count, cyc_m);
        check("instret_count", 0, instret_count, ret_m);
        @(posedge clk);
        #1;
`endif

        // fetch timeout: four waiting cycles, then sticky FAULT until reset
        for (int k = 0; k < 4; k++) step(100 + k, 10'b0100_000000, 3'd0, 9'b100_0000_00);
        step(104, 10'b0111_100000, 3'd7, 9'b000_0000_01);
        step(105, 10'b0111_100000, 3'd7, 9'b000_0000_01);
        step(106, 10'b1100_000000, 3'd7, 9'b000_0000_01);
        step(107, 10'b0000_000000, 3'd0, 9'b000_0000_00);

        // ack exactly on the fourth waiting cycle: no fault
        for (int k = 0; k < 3; k++) step(110 + k, 10'b0100_000000, 3'd0, 9'b100_0000_00);
        step(113, 10'b0110_000000, 3'd0, 9'b100_1000_00);
        step(114, 10'b0000_000000, 3'd1, 9'b000_0000_00);
        step(115, 10'b0000_000000, 3'd2, 9'b000_0000_00);
        step(116, 10'b0000_000000, 3'd4, 9'b000_0001_00);

        // store timeout in MEM
        step(120, 10'b0110_001000, 3'd0, 9'b100_1000_00);
        step(121, 10'b0000_001000, 3'd1, 9'b000_0000_00);
        step(122, 10'b0000_001000, 3'd2, 9'b000_0000_00);
        for (int k = 0; k < 4; k++) step(123 + k, 10'b0000_001000, 3'd3, 9'b011_0000_00);
        step(127, 10'b0001_001000, 3'd7, 9'b000_0000_01);
        step(128, 10'b1000_000000, 3'd7, 9'b000_0000_01);

        // reset while a data request is outstanding
        step(130, 10'b0110_110000, 3'd0, 9'b100_1000_00);
        step(131, 10'b0000_110000, 3'd1, 9'b000_0000_00);
        step(132, 10'b0000_110000, 3'd2, 9'b000_0000_00);
        step(133, 10'b0000_110000, 3'd3, 9'b010_0000_00);
        step(134, 10'b1000_110000, 3'd3, 9'b010_0000_00);
        step(135, 10'b0000_110000, 3'd0, 9'b000_0000_00);

`ifdef MULTICYCLE_PERF_CNT_EN
        @(negedge clk);
        check("cycle_count_end", 1, cycle_count, cyc_m);
        check("instret_count_end", 1, instret_count, ret_m);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
